fp_add_seq: RTL

Multi-cycle sequencer for the 32-bit floating-point adder in the Tomasulo FP add unit. Accepts one IEEE-754 single-precision add from the reservation station, then runs it through unpack, alignment, add, normalization and rounding steps. A single shared shifter serves both the alignment right-shift and the normalization shift. It returns the result with its reservation-station tag over a valid/ready handshake to the common data bus arbiter.

---
 rtl/fp_add_pkg.sv | 35 +++
 rtl/fp_shift_unit.sv | 33 +++
 rtl/fp_add_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared states, constants and operand unpacking for the FP add sequencer
package fp_add_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam int          MANT_W  = 23;
  localparam int          WORK_W  = 32;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [WORK_W-1:0] sig;
  } operand_t;

  // Working significand: bit31 carry, bits[30:7] = 1.m, bits[6:0] guard/extension
  function automatic operand_t unpack_op(input logic [31:0] v);
    operand_t o;
    o.sign = v[31];
    o.exp  = v[30:MANT_W];
    o.sig  = (o.exp == 8'd0) ? '0 : {1'b0, 1'b1, v[MANT_W-1:0], 7'b0};
    return o;
  endfunction

  function automatic logic [4:0] lzc31(input logic [30:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 0; i < 31; i++) begin
      if (v[i]) n = 5'(30 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_shift_unit.sv
// rtl/fp_shift_unit.sv - shared 32-bit left/right shifter, saturating to zero, with sticky of lost bits
module fp_shift_unit
  import fp_add_pkg::*;
(
  input  logic [WORK_W-1:0] i_data,
  input  logic [7:0]        i_amt,
  input  logic              i_left,
  output logic [WORK_W-1:0] o_data,
  output logic              o_sticky
);

  logic [2*WORK_W-1:0] w_right;
  logic [2*WORK_W-1:0] w_left;

  assign w_right = {i_data, {WORK_W{1'b0}}} >> i_amt[4:0];
  assign w_left  = {{WORK_W{1'b0}}, i_data} << i_amt[4:0];

  always_comb begin
    o_data   = '0;
    o_sticky = 1'b0;
    if (i_amt >= 8'd32) begin
      o_data   = '0;
      o_sticky = |i_data;
    end else if (i_left) begin
      o_data   = w_left[WORK_W-1:0];
      o_sticky = |w_left[2*WORK_W-1:WORK_W];
    end else begin
      o_data   = w_right[2*WORK_W-1:WORK_W];
      o_sticky = |w_right[WORK_W-1:0];
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle IEEE-754 single add sequencer with tag and valid/ready result
// FP_ADD_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fp_add_seq
  import fp_add_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  state_t              r_state;
  logic [31:0]         r_in_a, r_in_b;
  logic [TAG_W-1:0]    r_tag;
  logic                r_sign, r_eff_sub, r_zsign, r_zero, r_sticky;
  logic                r_special;
  logic [31:0]         r_spec_res;
  logic signed [9:0]   r_exp;
  logic [7:0]          r_d;
  logic [WORK_W-1:0]   r_sig_a, r_sig_b;
  logic                r_out_valid;
  logic [31:0]         r_out_result;
  logic [TAG_W-1:0]    r_out_tag;

  operand_t            w_op_a, w_op_b;
  logic [30:0]         w_key_a, w_key_b;
  logic                w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [WORK_W-1:0]   w_sum, w_sh_in, w_sh_out;
  logic [7:0]          w_sh_amt;
  logic                w_sh_left, w_sh_sticky;
  logic [4:0]          w_lz;
  logic                w_inc;
  logic [24:0]         w_rnd;
  logic signed [9:0]   w_exp_r;
  logic [22:0]         w_mant;
  logic [31:0]         w_final;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

  // Zeros (and flushed subnormals) compare as the smallest magnitude
  assign w_key_a = (r_in_a[30:23] == 8'd0) ? 31'd0 : r_in_a[30:0];
  assign w_key_b = (r_in_b[30:23] == 8'd0) ? 31'd0 : r_in_b[30:0];
  assign w_swap  = (w_key_b > w_key_a);
  assign w_op_a  = unpack_op(w_swap ? r_in_b : r_in_a);
  assign w_op_b  = unpack_op(w_swap ? r_in_a : r_in_b);

  assign w_nan_a = (r_in_a[30:23] == EXP_MAX) && (r_in_a[MANT_W-1:0] != '0);
  assign w_nan_b = (r_in_b[30:23] == EXP_MAX) && (r_in_b[MANT_W-1:0] != '0);
  assign w_inf_a = (r_in_a[30:23] == EXP_MAX) && (r_in_a[MANT_W-1:0] == '0);
  assign w_inf_b = (r_in_b[30:23] == EXP_MAX) && (r_in_b[MANT_W-1:0] == '0);

  // Borrowing the sticky keeps the difference a floor value so rounding stays exact
  assign w_sum = r_eff_sub ? (r_sig_a - r_sig_b - {{(WORK_W-1){1'b0}}, r_sticky})
                           : (r_sig_a + r_sig_b);

  assign w_lz      = lzc31(r_sig_a[30:0]);
  assign w_sh_in   = (r_state == NORM) ? r_sig_a : r_sig_b;
  assign w_sh_left = (r_state == NORM) && !r_sig_a[31];
  assign w_sh_amt  = (r_state != NORM) ? r_d : (r_sig_a[31] ? 8'd1 : {3'b0, w_lz});

  fp_shift_unit u_shift (
    .i_data   (w_sh_in),
    .i_amt    (w_sh_amt),
    .i_left   (w_sh_left),
    .o_data   (w_sh_out),
    .o_sticky (w_sh_sticky)
  );

`ifdef FP_ADD_RNE_EN
  logic w_guard, w_round, w_sticky_all;
  assign w_guard      = r_sig_a[6];
  assign w_round      = r_sig_a[5];
  assign w_sticky_all = (|r_sig_a[4:0]) | r_sticky;
  assign w_inc        = w_guard & (w_round | w_sticky_all | r_sig_a[7]);
`else
  assign w_inc = 1'b0;
`endif

  assign w_rnd   = {1'b0, r_sig_a[30:7]} + {24'd0, w_inc};
  assign w_exp_r = r_exp + $signed({9'd0, w_rnd[24]});
  assign w_mant  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

  always_comb begin
    w_final = {r_sign, 31'd0};
    if (r_special)                 w_final = r_spec_res;
    else if (r_zero)               w_final = {r_zsign, 31'd0};
    else if (r_exp <= 10'sd0)      w_final = {r_sign, 31'd0};
    else if (w_exp_r >= 10'sd255)  w_final = {r_sign, EXP_MAX, 23'd0};
    else                           w_final = {r_sign, w_exp_r[7:0], w_mant};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in_a  <= in_a;
          r_in_b  <= in_b;
          r_tag   <= in_tag;
          r_state <= UNPACK;
        end
        UNPACK: begin
          r_sign     <= w_op_a.sign;
          r_eff_sub  <= w_op_a.sign ^ w_op_b.sign;
          r_zsign    <= r_in_a[31] & r_in_b[31];
          r_exp      <= $signed({2'b0, w_op_a.exp});
          r_d        <= w_op_a.exp - w_op_b.exp;
          r_sig_a    <= w_op_a.sig;
          r_sig_b    <= w_op_b.sig;
          r_special  <= w_nan_a | w_nan_b | w_inf_a | w_inf_b;
          r_spec_res <= (w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (r_in_a[31] ^ r_in_b[31])))
                        ? QNAN : (w_inf_a ? r_in_a : r_in_b);
          r_state    <= ALIGN;
        end
        ALIGN: begin
          r_sig_b  <= w_sh_out;
          r_sticky <= w_sh_sticky;
          r_state  <= ADD;
        end
        ADD: begin
          r_sig_a <= w_sum;
          r_zero  <= (w_sum == '0);
          r_state <= NORM;
        end
        NORM: begin
          r_sig_a  <= w_sh_out;
          r_sticky <= r_sticky | w_sh_sticky;
          r_exp    <= r_sig_a[31] ? (r_exp + 10'sd1) : (r_exp - $signed({5'd0, w_lz}));
          r_state  <= ROUND;
        end
        ROUND: begin
          r_out_result <= w_final;
          r_out_tag    <= r_tag;
          r_out_valid  <= 1'b1;
          r_state      <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
